// File: rtl/pc_pkg.sv
// Shared CPU constants: address width, fetch increment and reset vector.
package pc_pkg;
  localparam int              ADDR_W    = 16;
  localparam int              PC_INC    = 2;
  localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;
endpackage

// File: rtl/pc_if.sv
// Program-counter signal bundle between the fetch stage and the PC register.
import pc_pkg::*;

interface pc_if #(parameter int WIDTH = ADDR_W);
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_count;
  logic [WIDTH-1:0] pc_branch;

  modport master (output pc_next, input pc_count, input pc_branch);
  modport slave  (input pc_next, output pc_count, output pc_branch);
endinterface

// File: rtl/pc.sv
// Program counter: one register loading pc_next every cycle, plus a
// combinational adder giving the fall-through address pc_count + INC.
import pc_pkg::*;

module pc #(
  parameter int               WIDTH     = ADDR_W,
  parameter int               INC       = PC_INC,
  parameter logic [WIDTH-1:0] RESET_VAL = RESET_VEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc_count,
  output logic [WIDTH-1:0] pc_branch
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_count <= RESET_VAL;
    else        pc_count <= pc_next;
  end

  // Wraps modulo 2^WIDTH; no carry out is needed by the fetch path.
  assign pc_branch = pc_count + WIDTH'(INC);

endmodule

// File: tb/tb_pc.sv
// Directed bench for the program counter: reset, load, wrap, async reset.
module tb_pc;
  import pc_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pc_if #(.WIDTH(16)) bus ();

  pc #(.WIDTH(16), .INC(2), .RESET_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_next   (bus.pc_next),
    .pc_count  (bus.pc_count),
    .pc_branch (bus.pc_branch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edge_n(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // scenario 1: held in reset while clocking
    rst_n = 1'b0;
    bus.pc_next = 16'h1234;
    #1;
    chk("rst_cnt_t0", bus.pc_count, 16'h0000);
    chk("rst_br_t0",  bus.pc_branch, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      edge_n(1);
      chk("rst_cnt", bus.pc_count, 16'h0000);
      chk("rst_br",  bus.pc_branch, 16'h0002);
    end

    // scenario 2: release mid-cycle, then basic loads
    rst_n = 1'b1;
    bus.pc_next = 16'h0000;
    edge_n(2);
    chk("ld0_cnt", bus.pc_count, 16'h0000);
    chk("ld0_br",  bus.pc_branch, 16'h0002);
    bus.pc_next = 16'h0001;
    edge_n(1);
    chk("ld1_cnt", bus.pc_count, 16'h0001);
    chk("ld1_br",  bus.pc_branch, 16'h0003);
    bus.pc_next = 16'h0005;
    edge_n(1);
    chk("ld5_cnt", bus.pc_count, 16'h0005);
    chk("ld5_br",  bus.pc_branch, 16'h0007);

    // scenario 3: mid-cycle pc_next glitch must not leak through
    bus.pc_next = 16'h0003;
    edge_n(1);
    chk("ld3_cnt", bus.pc_count, 16'h0003);
    bus.pc_next = 16'h0005;
    #1 bus.pc_next = 16'h0009;
    #1;
    chk("glitch_cnt", bus.pc_count, 16'h0003);
    chk("glitch_br",  bus.pc_branch, 16'h0005);
    bus.pc_next = 16'h0005;
    #1;
    chk("glitch_cnt2", bus.pc_count, 16'h0003);
    edge_n(1);
    chk("after_glitch", bus.pc_count, 16'h0005);
    chk("after_glitch_br", bus.pc_branch, 16'h0007);

    // scenario 4: adder wraps at the top of the address space
    bus.pc_next = 16'hFFFE;
    edge_n(1);
    chk("fffe_cnt", bus.pc_count, 16'hFFFE);
    chk("fffe_br",  bus.pc_branch, 16'h0000);
    bus.pc_next = 16'hFFFF;
    edge_n(1);
    chk("ffff_cnt", bus.pc_count, 16'hFFFF);
    chk("ffff_br",  bus.pc_branch, 16'h0001);

    // scenario 5: asynchronous reset assertion mid-cycle
    bus.pc_next = 16'h00A0;
    edge_n(1);
    chk("a0_cnt", bus.pc_count, 16'h00A0);
    chk("a0_br",  bus.pc_branch, 16'h00A2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_cnt", bus.pc_count, 16'h0000);
    chk("async_br",  bus.pc_branch, 16'h0002);

    // scenario 6: release coincident with a rising edge is ignored
    bus.pc_next = 16'h0040;
    @(negedge clk);
    @(posedge clk);
    #0 rst_n = 1'b1;
    @(negedge clk);
    chk("coinc_cnt", bus.pc_count, 16'h0000);
    chk("coinc_br",  bus.pc_branch, 16'h0002);
    edge_n(1);
    chk("post_cnt", bus.pc_count, 16'h0040);
    chk("post_br",  bus.pc_branch, 16'h0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
